// File: rtl/aqp_esp_uart_rx_ctrl_pkg.sv
// Shared ESP UART constants: receive FIFO sizing, flow-control
// thresholds and status-register bit positions.
package aqp_esp_uart_rx_ctrl_pkg;

    localparam int ESP_RX_DEPTH  = 16;
    localparam int ESP_RX_RTS_HI = 12;
    localparam int ESP_RX_RTS_LO = 4;

    // Status register bit positions, reused by the register map
    localparam int STAT_OVF_BIT   = 0;
    localparam int STAT_FERR_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } rx_state_e;

    function automatic logic [2:0] pack_status(
        input logic ovf,
        input logic ferr,
        input logic empty
    );
        logic [2:0] s;
        s                 = '0;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_FERR_BIT]  = ferr;
        s[STAT_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/aqp_esp_uart_rx_ctrl_if.sv
// Receiver-side and CPU-side signals of the ESP UART receive
// controller; the controller takes the slave view.
interface aqp_esp_uart_rx_ctrl_if
    import aqp_esp_uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = ESP_RX_DEPTH
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ferr;
    logic                   rd_strobe;
    logic                   flush;
    logic                   clr_status;
    logic [7:0]             rd_data;
    logic                   rx_empty;
    logic [$clog2(DEPTH):0] rx_count;
    logic                   uart_rts_n;
    logic                   overflow;
    logic                   ferr_sticky;

    modport master (
        output rx_data, rx_valid, rx_ferr,
        output rd_strobe, flush, clr_status,
        input  rd_data, rx_empty, rx_count,
        input  uart_rts_n, overflow, ferr_sticky
    );

    modport slave (
        input  rx_data, rx_valid, rx_ferr,
        input  rd_strobe, flush, clr_status,
        output rd_data, rx_empty, rx_count,
        output uart_rts_n, overflow, ferr_sticky
    );
endinterface

// File: rtl/aqp_fifo_ram.sv
// FIFO storage array: one synchronous write port and one
// asynchronous read port; contents are not reset.
module aqp_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/aqp_esp_uart_rx_ctrl.sv
// ESP UART receive controller: byte FIFO with RTS hysteresis,
// framing-error tracking and sticky overflow/error flags.
module aqp_esp_uart_rx_ctrl
    import aqp_esp_uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH  = ESP_RX_DEPTH,
    parameter int RTS_HI = ESP_RX_RTS_HI,
    parameter int RTS_LO = ESP_RX_RTS_LO
) (
    input logic                   clk,
    input logic                   reset,
    aqp_esp_uart_rx_ctrl_if.slave bus_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] HI_LVL   = CW'(RTS_HI);
    localparam logic [CW-1:0] LO_LVL   = CW'(RTS_LO);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rts_q, rts_d;
    logic          ovf_q, ovf_d;
    logic          ferr_q;
    logic          prev_ferr_q;
    rx_state_e     state_q;

    logic          empty, full;
    logic          push_req, do_push, do_pop;
    logic          drop, ferr_rise;
    logic [7:0]    ram_rdata;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_LVL);
        push_req  = (state_q == ST_RUN) && bus_if.rx_valid && !bus_if.rx_ferr;
        do_pop    = bus_if.rd_strobe && !empty;
        // A pop at full frees the slot the concurrent push lands in
        do_push   = push_req && (!full || do_pop);
        drop      = push_req && full && !do_pop;
        ferr_rise = bus_if.rx_ferr && !prev_ferr_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ovf_d    = (ovf_q && !bus_if.clr_status) || drop;
        rts_d    = rts_q;
        if (count_q >= HI_LVL) begin
            rts_d = 1'b1;
        end else if (count_q <= LO_LVL) begin
            rts_d = 1'b0;
        end
        if (bus_if.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            rts_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rts_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rts_q    <= rts_d;
        end
    end

    // Receiver error FSM; flush clears the flag but not the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            prev_ferr_q <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            prev_ferr_q <= bus_if.rx_ferr;
            unique case (state_q)
                ST_RUN:   if (ferr_rise) state_q <= ST_ERROR;
                ST_ERROR: if (!bus_if.rx_ferr) state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
            if (bus_if.flush) begin
                ferr_q <= 1'b0;
            end else begin
                ferr_q <= (ferr_q && !bus_if.clr_status) || ferr_rise;
            end
        end
    end

    aqp_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_ram (
        .clk     (clk),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus_if.rx_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign bus_if.rd_data     = empty ? 8'h00 : ram_rdata;
    assign bus_if.rx_empty    = empty;
    assign bus_if.rx_count    = count_q;
    assign bus_if.uart_rts_n  = rts_q;
    assign bus_if.overflow    = ovf_q;
    assign bus_if.ferr_sticky = ferr_q;
endmodule
